// File: rtl/stopwatch_ctrl_pkg.sv
// Shared stopwatch state encoding, used by the controller, the display mux and the LED logic.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_LAP   = 2'd2,
      ST_PAUSE = 2'd3
   } sw_state_e;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button/tick inputs and counter/display control outputs of the stopwatch controller.
interface stopwatch_ctrl_if;
   import stopwatch_pkg::*;

   logic       btn_start;
   logic       btn_lap;
   logic       tick;
   logic       count_en;
   logic       cnt_clr;
   logic       disp_freeze;
   logic [1:0] state;

   modport master (
      output btn_start, btn_lap, tick,
      input  count_en, cnt_clr, disp_freeze, state
   );

   modport slave (
      input  btn_start, btn_lap, tick,
      output count_en, cnt_clr, disp_freeze, state
   );

endinterface

// File: rtl/stopwatch_ctrl_debounce.sv
// Synchronize, debounce and edge-detect one raw push-button into a single-cycle press pulse.
// A raw rise sampled at edge 1 sets db at edge DEB_LEN+2 and press is high after edge DEB_LEN+3.
module btn_debounce_pulse #(
   parameter int DEB_LEN = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic press
);
   localparam int CNT_W = $clog2(DEB_LEN);

   logic             meta_q, sync_q;
   logic             db_q, db_d;
   logic             db_dly_q;
   logic             press_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The stability counter only runs while the synchronized level disagrees with db.
   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (sync_q != db_q) begin
         if (cnt_q == CNT_W'(DEB_LEN - 1)) begin
            db_d = sync_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         meta_q   <= 1'b0;
         sync_q   <= 1'b0;
         db_q     <= 1'b0;
         cnt_q    <= '0;
         db_dly_q <= 1'b0;
         press_q  <= 1'b0;
      end else begin
         meta_q   <= raw;
         sync_q   <= meta_q;
         db_q     <= db_d;
         cnt_q    <= cnt_d;
         db_dly_q <= db_q;
         press_q  <= db_q & ~db_dly_q;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear sequencer for the stopwatch counter; state moves DEB_LEN+4 edges after a press.
// count_en is tick gated by the current (pre-transition) state, with no added latency.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int DEB_LEN = 1000000
) (
   input  logic            clk,
   input  logic            rst_n,
   stopwatch_ctrl_if.slave sw
);
   logic      start_p, lap_p;
   sw_state_e state_q, state_d;
   logic      count_en, cnt_clr, disp_freeze;

   btn_debounce_pulse #(.DEB_LEN(DEB_LEN)) u_start_btn (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (sw.btn_start),
      .press (start_p)
   );

   btn_debounce_pulse #(.DEB_LEN(DEB_LEN)) u_lap_btn (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (sw.btn_lap),
      .press (lap_p)
   );

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Start is tested first everywhere, so a coincident lap press is dropped.
   always_comb begin
      state_d     = state_q;
      count_en    = 1'b0;
      cnt_clr     = 1'b0;
      disp_freeze = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            if (start_p) state_d = ST_RUN;
         end
         ST_RUN: begin
            count_en = sw.tick;
            if (start_p)    state_d = ST_PAUSE;
            else if (lap_p) state_d = ST_LAP;
         end
         ST_LAP: begin
            count_en    = sw.tick;
            disp_freeze = 1'b1;
            if (start_p)    state_d = ST_PAUSE;
            else if (lap_p) state_d = ST_RUN;
         end
         ST_PAUSE: begin
            if (start_p)    state_d = ST_RUN;
            else if (lap_p) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign sw.count_en    = count_en;
   assign sw.cnt_clr     = cnt_clr;
   assign sw.disp_freeze = disp_freeze;
   assign sw.state       = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized and directed bench for stopwatch_ctrl against a window-based behavioural model.
module tb_stopwatch_ctrl;
   import stopwatch_pkg::*;

   localparam int DEB = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   stopwatch_ctrl_if sw ();

   stopwatch_ctrl #(.DEB_LEN(DEB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sw    (sw)
   );

   int errors = 0;
   int checks = 0;
   int gcyc   = 0;

   // Model: db flips once the last DEB synchronized samples all disagree with it;
   // a rise reaches the FSM two edges later.
   int   m_state;
   logic hist_s[$];
   logic hist_l[$];
   logic mdb_s, mdb_l, r1_s, r2_s, r1_l, r2_l;
   logic in_rst;
   logic cur_t;

   task automatic model_reset();
      m_state = 0;
      hist_s.delete();
      hist_l.delete();
      for (int i = 0; i <= DEB; i++) begin
         hist_s.push_back(1'b0);
         hist_l.push_back(1'b0);
      end
      mdb_s = 1'b0; mdb_l = 1'b0;
      r1_s = 1'b0; r2_s = 1'b0; r1_l = 1'b0; r2_l = 1'b0;
   endtask

   function automatic logic window_flips(input logic h[$], input logic db);
      for (int i = 0; i < DEB; i++) if (h[i] == db) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_edge(input logic s, input logic l);
      logic ps, pl, rs, rl;
      ps = r2_s;
      pl = r2_l;
      case (m_state)
         0: if (ps) m_state = 1;
         1: if (ps) m_state = 3; else if (pl) m_state = 2;
         2: if (ps) m_state = 3; else if (pl) m_state = 1;
         default: if (ps) m_state = 1; else if (pl) m_state = 0;
      endcase
      rs = 1'b0;
      rl = 1'b0;
      if (window_flips(hist_s, mdb_s)) begin mdb_s = ~mdb_s; rs = mdb_s; end
      if (window_flips(hist_l, mdb_l)) begin mdb_l = ~mdb_l; rl = mdb_l; end
      r2_s = r1_s; r1_s = rs;
      r2_l = r1_l; r1_l = rl;
      hist_s.push_back(s); void'(hist_s.pop_front());
      hist_l.push_back(l); void'(hist_l.pop_front());
   endtask

   function automatic logic [4:0] exp_vec();
      logic [1:0] st;
      st = m_state[1:0];
      return {st, m_state == 0, m_state == 2, cur_t && (m_state == 1 || m_state == 2)};
   endfunction

   function automatic logic [4:0] act_vec();
      return {sw.state, sw.cnt_clr, sw.disp_freeze, sw.count_en};
   endfunction

   // One clock: model takes the edge with the held inputs, then new inputs are driven.
   task automatic cyc(input logic s, input logic l, input logic t);
      @(posedge clk);
      if (!in_rst) model_edge(sw.btn_start, sw.btn_lap);
      @(negedge clk);
      sw.btn_start = s;
      sw.btn_lap   = l;
      sw.tick      = t;
      cur_t        = t;
      gcyc++;
      #1;
   endtask

   task automatic hold_btn(input logic s, input logic l, input int n);
      for (int i = 0; i < n; i++) cyc(s, l, (gcyc % 3) == 0);
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      in_rst = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 1'b1);
         checks++;
         if (act_vec() !== 5'b00_1_0_0) begin
            errors++;
            $display("FAIL reset_hold: got %b exp %b", act_vec(), 5'b00_1_0_0);
         end
      end
      @(negedge clk);
      rst_n  = 1'b0;
      in_rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
         checks++;
         if (act_vec() !== {4'b00_1_0, 1'b0} || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle: cycle %0d got %b exp %b", i, act_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_start_latency();
      int first_run = -1;
      int trans = 0;
      logic [1:0] prev;
      prev = sw.state;
      for (int i = 1; i <= 20; i++) begin
         cyc(1'b1, 1'b0, 1'b0);
         if (sw.state !== prev) trans++;
         if (sw.state == 2'd1 && first_run < 0) first_run = i;
         prev = sw.state;
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL start_hold: cycle %0d got %b exp %b", i, act_vec(), exp_vec());
         end
      end
      // Raw rise first sampled on cycle 2's edge; state moves on the 8th sampled edge.
      checks++;
      if (first_run != 9) begin
         errors++;
         $display("FAIL start_latency: got cycle %0d exp cycle 9", first_run);
      end
      checks++;
      if (trans != 1) begin
         errors++;
         $display("FAIL start_single_pulse: got %0d transitions exp 1", trans);
      end
      for (int i = 0; i < 30; i++) begin
         cyc(1'b0, 1'b0, (i % 5) == 0);
         checks++;
         if (sw.count_en !== ((i % 5) == 0) || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL run_tick: cycle %0d got %b exp %b", i, act_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_bounce();
      logic pat [7];
      int trans = 0;
      logic [1:0] prev;
      pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      prev = sw.state;
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 7; k++) begin
            cyc(pat[k], 1'b0, 1'b0);
            checks++;
            if (sw.state !== prev || act_vec() !== exp_vec()) begin
               errors++;
               $display("FAIL bounce_reject: got %b exp %b", act_vec(), exp_vec());
            end
         end
      end
      for (int i = 0; i < 20; i++) begin
         cyc(i < 10, 1'b0, 1'b0);
         if (sw.state !== prev) trans++;
         prev = sw.state;
      end
      checks++;
      if (trans != 1 || sw.state !== 2'd3) begin
         errors++;
         $display("FAIL bounce_then_hold: got %0d transitions state %0d exp 1 transition state 3",
                  trans, sw.state);
      end
   endtask

   task automatic test_full_cycle();
      hold_btn(1'b1, 1'b0, 8); hold_btn(1'b0, 1'b0, 8);
      checks++;
      if (sw.state !== 2'd1) begin errors++; $display("FAIL full_run: got %0d exp 1", sw.state); end
      hold_btn(1'b0, 1'b1, 8); hold_btn(1'b0, 1'b0, 8);
      cyc(1'b0, 1'b0, 1'b1);
      checks++;
      if (act_vec() !== 5'b10_0_1_1) begin
         errors++; $display("FAIL full_lap: got %b exp %b", act_vec(), 5'b10_0_1_1);
      end
      hold_btn(1'b0, 1'b1, 8); hold_btn(1'b0, 1'b0, 8);
      cyc(1'b0, 1'b0, 1'b0);
      checks++;
      if (act_vec() !== 5'b01_0_0_0) begin
         errors++; $display("FAIL full_unfreeze: got %b exp %b", act_vec(), 5'b01_0_0_0);
      end
      hold_btn(1'b1, 1'b0, 8); hold_btn(1'b0, 1'b0, 8);
      cyc(1'b0, 1'b0, 1'b1);
      checks++;
      if (act_vec() !== 5'b11_0_0_0) begin
         errors++; $display("FAIL full_pause: got %b exp %b", act_vec(), 5'b11_0_0_0);
      end
      hold_btn(1'b0, 1'b1, 8); hold_btn(1'b0, 1'b0, 8);
      checks++;
      if (act_vec() !== 5'b00_1_0_0 || act_vec() !== exp_vec()) begin
         errors++; $display("FAIL full_clear: got %b exp %b", act_vec(), 5'b00_1_0_0);
      end
   endtask

   task automatic test_simultaneous();
      hold_btn(1'b0, 1'b1, 8); hold_btn(1'b0, 1'b0, 8);
      checks++;
      if (sw.state !== 2'd0) begin errors++; $display("FAIL lap_in_idle: got %0d exp 0", sw.state); end
      hold_btn(1'b1, 1'b0, 8); hold_btn(1'b0, 1'b0, 8);
      hold_btn(1'b1, 1'b1, 8); hold_btn(1'b0, 1'b0, 8);
      checks++;
      if (sw.state !== 2'd3 || act_vec() !== exp_vec()) begin
         errors++; $display("FAIL simultaneous: got state %0d exp 3", sw.state);
      end
   endtask

   task automatic test_lap_to_pause();
      int hit = 0;
      logic fr_prev;
      hold_btn(1'b1, 1'b0, 8); hold_btn(1'b0, 1'b0, 8);
      hold_btn(1'b0, 1'b1, 8); hold_btn(1'b0, 1'b0, 8);
      fr_prev = sw.disp_freeze;
      for (int i = 0; i < 16; i++) begin
         cyc(i < 8, 1'b0, 1'b1);
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++; $display("FAIL lap_start: cycle %0d got %b exp %b", i, act_vec(), exp_vec());
         end
         if (sw.state == 2'd3 && hit == 0) begin
            hit = 1;
            checks++;
            if (sw.disp_freeze !== 1'b0 || fr_prev !== 1'b1) begin
               errors++;
               $display("FAIL lap_freeze_drop: got freeze %b prev %b exp 0 prev 1", sw.disp_freeze, fr_prev);
            end
         end
         fr_prev = sw.disp_freeze;
      end
      checks++;
      if (hit != 1) begin errors++; $display("FAIL lap_start_reached: got %0d exp 1", hit); end
   endtask

   task automatic test_random();
      for (int seg = 0; seg < 40; seg++) begin
         logic s, l;
         int n;
         s = ($urandom_range(0, 2) == 0);
         l = ($urandom_range(0, 2) == 0);
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) begin
            cyc(s, l, $urandom_range(0, 3) == 0);
            checks++;
            if (act_vec() !== exp_vec()) begin
               errors++;
               $display("FAIL random: seg %0d got %b exp %b", seg, act_vec(), exp_vec());
            end
         end
      end
   endtask

   task automatic test_async_reset();
      hold_btn(1'b0, 1'b0, 10);
      rst_n = 1'b1; in_rst = 1'b1; model_reset();
      hold_btn(1'b0, 1'b0, 2);
      @(negedge clk); rst_n = 1'b0; in_rst = 1'b0;
      hold_btn(1'b1, 1'b0, 10); hold_btn(1'b0, 1'b0, 6);
      cyc(1'b0, 1'b0, 1'b1);
      checks++;
      if (act_vec() !== 5'b01_0_0_1) begin
         errors++; $display("FAIL pre_async_run: got %b exp %b", act_vec(), 5'b01_0_0_1);
      end
      #1 rst_n = 1'b1;
      in_rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (act_vec() !== 5'b00_1_0_0) begin
         errors++; $display("FAIL async_reset: got %b exp %b", act_vec(), 5'b00_1_0_0);
      end
      hold_btn(1'b0, 1'b0, 3);
      @(negedge clk); rst_n = 1'b0; in_rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc(1'b0, 1'b0, 1'b1);
         checks++;
         if (act_vec() !== exp_vec() || sw.state !== 2'd0) begin
            errors++; $display("FAIL post_reset_idle: got %b exp %b", act_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      rst_n        = 1'b1;
      in_rst       = 1'b1;
      cur_t        = 1'b0;
      sw.btn_start = 1'b0;
      sw.btn_lap   = 1'b0;
      sw.tick      = 1'b0;
      model_reset();
      test_reset();
      test_start_latency();
      test_bounce();
      test_full_cycle();
      test_simultaneous();
      test_lap_to_pause();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Run/pause/lap/clear controller for the stopwatch counter datapath. It takes two raw push-buttons (start/pause and lap/clear) and a periodic tick from the clock divider. It debounces each button, turns each press into a single one-cycle pulse, and sequences the counter through a 4-state FSM. It drives the counter's enable and clear inputs and the display freeze control.

Parameters:
DEB_LEN, 1000000, consecutive clk cycles a synchronized button level must differ from the debounced level before the debounced level changes; must be >= 2 (bench uses 4).
CNT_W, $clog2(DEB_LEN), width of each debounce stability counter (derived; do not override).

Ports:
clk  in  1  system clock; the only clock.
rst_n  in  1  reset; asynchronous, active-high despite the name (1 = reset).
btn_start  in  1  raw start/pause button, asynchronous, may bounce.
btn_lap  in  1  raw lap/clear button, asynchronous, may bounce.
tick  in  1  one-cycle enable pulse from the divider (count rate).
count_en  out  1  counter increment enable.
cnt_clr  out  1  counter synchronous clear.
disp_freeze  out  1  display holds its last latched value while high.
state  out  2  current FSM state, for LEDs/debug.

Behaviour:
- Reset and clocking: one clock, clk. Reset is asynchronous and active-high on rst_n. All flops clear on reset: synchronizers, debounced levels, stability counters, pulse flops, state=IDLE.
- Reset output values: state=2'd0, cnt_clr=1, count_en=0, disp_freeze=0.
- Reset mid-operation (any state, any debounce progress): return to IDLE immediately; partial debounce counts are discarded.
- Per-button front end:
  - 2-FF synchronizer feeds sync.
  - Every edge where sync != db: if cnt == DEB_LEN-1, then db <= sync and cnt <= 0; otherwise cnt++.
  - Any edge where sync == db: cnt <= 0. Bounces shorter than DEB_LEN cycles never change db.
  - press pulse: registered db & ~db_d, high exactly 1 cycle per debounced rising edge. Releases generate nothing. Holding the button generates exactly one pulse.
- Latency: raw rising edge first sampled at edge 1 → db=1 at edge DEB_LEN+2 → press=1 after edge DEB_LEN+3 → state changes at edge DEB_LEN+4.
- FSM (registered; outputs are Moore except count_en):
  - IDLE (0): cnt_clr=1.
    - start → RUN.
    - lap ignored.
  - RUN (1): count_en=tick.
    - start → PAUSE.
    - lap → LAP.
  - LAP (2): count_en=tick, disp_freeze=1 (counting continues, display frozen).
    - lap → RUN (unfreeze).
    - start → PAUSE (unfreeze).
  - PAUSE (3): count_en=0.
    - start → RUN.
    - lap → IDLE, so the counter is cleared.
- count_en = tick when state is RUN or LAP, else 0. It is combinational from state and tick, with no extra latency.
- Simultaneous start and lap pulses in the same cycle: start wins, lap is dropped.
- A tick coinciding with a transition uses the pre-transition state. Example: a tick on the cycle PAUSE→RUN is registered gives count_en=0.
- Unreachable state encodings: none exist (all 4 are used). The default branch goes to IDLE.

Decomposition:
- Package stopwatch_pkg: state localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_LAP=2'd2, ST_PAUSE=2'd3; shared by the display mux and LED logic.
- Sub-module btn_debounce_pulse(clk, rst_n, raw, press), parameter DEB_LEN. It contains the synchronizer, stability counter, db register and one-pulse. It is instantiated twice.
- stopwatch_ctrl holds only the FSM and the output decode.

Test Plan:
- Reset, then reset released with buttons idle → state=0, cnt_clr=1, count_en=0, disp_freeze=0 for 50 cycles. Assert rst_n asynchronously mid-cycle while in RUN → all outputs return to reset values before the next clk edge.
- DEB_LEN=4, clean btn_start press held 20 cycles → state goes 0→1 at edge 8 after first sample, exactly one press pulse. Then tick every 5 cycles → count_en pulses coincide with tick.
- Bounce rejection: btn_start pattern 1,1,1,0,1,1,0 repeated → no state change. Then hold 1 for 10 cycles → exactly one transition.
- Full cycle: start→RUN, lap→LAP (disp_freeze=1, count_en still follows tick), lap→RUN (freeze=0), start→PAUSE (count_en=0 despite tick), lap→IDLE (cnt_clr=1).
- Simultaneous: both buttons debounced on the same cycle while in RUN → state=PAUSE, not LAP. Lap pulse alone in IDLE → stays IDLE.
- Start pressed in LAP → PAUSE with disp_freeze dropping to 0 on the same edge.
